// File: rtl/bnn_ctrl_pkg.sv
// Shared types and constants for the BNN host command controller.
// States, status/error codes and default command bytes.
package bnn_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IMG,
      S_IMG_RX,
      S_WR_WAIT,
      S_BNN_RUN,
      S_RESULT,
      S_ERROR,
      S_CLEAR
   } state_t;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_RX_RDY   = 4'd1;
   localparam logic [3:0] ST_RX       = 4'd2;
   localparam logic [3:0] ST_BNN_BUSY = 4'd4;
   localparam logic [3:0] ST_RESULT   = 4'd8;
   localparam logic [3:0] ST_ERROR    = 4'd14;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_BAD_CMD = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_OVERRUN = 2'd3;

   localparam logic [7:0] CMD_IMG_DEF   = 8'hFE;
   localparam logic [7:0] CMD_CLEAR_DEF = 8'hFD;
   localparam logic [7:0] CMD_READ_DEF  = 8'hFC;

   // CLEAR is transient and reports like IDLE
   function automatic logic [3:0] status_of(state_t s);
      logic [3:0] r;
      r = ST_IDLE;
      unique case (s)
         S_IDLE:     r = ST_IDLE;
         S_WAIT_IMG: r = ST_RX_RDY;
         S_IMG_RX:   r = ST_RX;
         S_WR_WAIT:  r = ST_RX;
         S_BNN_RUN:  r = ST_BNN_BUSY;
         S_RESULT:   r = ST_RESULT;
         S_ERROR:    r = ST_ERROR;
         S_CLEAR:    r = ST_IDLE;
         default:    r = ST_IDLE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bnn_host_ctrl_fsm_if.sv
// Signal bundle between the host controller and its peripherals.
// master = controller, slave = receiver/buffer/BNN/transmitter side.
interface bnn_host_ctrl_fsm_if #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 7,
   parameter int RESULT_W = 4
);
   logic [DATA_W-1:0]   rx_data;
   logic                rx_valid;
   logic                rx_taken;
   logic                rx_enable;
   logic                wr_req;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                wr_ready;
   logic                wr_ack;
   logic                clear;
   logic                buffer_empty;
   logic                bnn_start;
   logic                bnn_done;
   logic [RESULT_W-1:0] bnn_result;
   logic [DATA_W-1:0]   tx_data;
   logic                tx_load;
   logic [3:0]          status_code;
   logic [1:0]          err_code;

   modport master (
      input  rx_data, rx_valid, wr_ready, wr_ack,
      input  buffer_empty, bnn_done, bnn_result,
      output rx_taken, rx_enable, wr_req, wr_addr,
      output wr_data, clear, bnn_start, tx_data,
      output tx_load, status_code, err_code
   );

   modport slave (
      output rx_data, rx_valid, wr_ready, wr_ack,
      output buffer_empty, bnn_done, bnn_result,
      input  rx_taken, rx_enable, wr_req, wr_addr,
      input  wr_data, clear, bnn_start, tx_data,
      input  tx_load, status_code, err_code
   );
endinterface

// File: rtl/bnn_host_ctrl_fsm_rx_timeout_timer.sv
// Reloadable down-counter flagging an idle gap between image bytes.
// TIMEOUT_CYC = 0 builds no counter and never expires.
module rx_timeout_timer #(
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic reload,
   input  logic enable,
   output logic expired
);
   if (TIMEOUT_CYC == 0) begin : g_off
      assign expired = 1'b0;
   end else begin : g_on
      localparam int W = $clog2(TIMEOUT_CYC + 1);
      localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYC);

      logic [W-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
         end else if (reload) begin
            cnt <= LOAD;
         end else if (enable && cnt != '0) begin
            cnt <= cnt - W'(1);
         end
      end

      // a byte arriving in the same cycle rescues the frame
      assign expired = enable & ~reload & (cnt == '0);
   end
endmodule

// File: rtl/bnn_host_ctrl_fsm.sv
// Host command controller: SPI bytes -> image buffer -> BNN -> readback.
// All outputs are registered; status lags the state by one cycle.
module bnn_host_ctrl_fsm
   import bnn_ctrl_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int IMG_BYTES   = 113,
   parameter int ADDR_W      = $clog2(IMG_BYTES),
   parameter int RESULT_W    = 4,
   parameter int TIMEOUT_CYC = 1000000,
   parameter logic [DATA_W-1:0] CMD_IMG   = DATA_W'(CMD_IMG_DEF),
   parameter logic [DATA_W-1:0] CMD_CLEAR = DATA_W'(CMD_CLEAR_DEF),
   parameter logic [DATA_W-1:0] CMD_READ  = DATA_W'(CMD_READ_DEF)
) (
   input logic clk,
   input logic rst_n,
   bnn_host_ctrl_fsm_if.master bus
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_BYTES - 1);

   state_t              state, state_n;
   logic                rx_q, new_byte;
   logic                is_img, is_clr, is_rd;
   logic [ADDR_W-1:0]   count, count_n;
   logic                skid_vld, skid_vld_n;
   logic [DATA_W-1:0]   skid_dat, skid_dat_n;
   logic [RESULT_W-1:0] res_q, res_n;
   logic [1:0]          err_q, err_n;
   logic                issue;
   logic [DATA_W-1:0]   issue_dat;
   logic                taken, load, start, bad;
   logic                tmr_en, expired;

   assign new_byte = bus.rx_valid & ~rx_q;
   assign is_img   = bus.rx_data == CMD_IMG;
   assign is_clr   = bus.rx_data == CMD_CLEAR;
   assign is_rd    = bus.rx_data == CMD_READ;
   assign tmr_en   = state inside {S_WAIT_IMG, S_IMG_RX, S_WR_WAIT};

   rx_timeout_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_tmr (
      .clk    (clk),
      .rst_n  (rst_n),
      .reload (new_byte),
      .enable (tmr_en),
      .expired(expired)
   );

   always_comb begin
      state_n    = state;
      count_n    = count;
      skid_vld_n = skid_vld;
      skid_dat_n = skid_dat;
      res_n      = res_q;
      err_n      = err_q;
      issue      = 1'b0;
      issue_dat  = skid_dat;
      taken      = 1'b0;
      load       = 1'b0;
      start      = 1'b0;
      bad        = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (new_byte) begin
               taken = 1'b1;
               unique case (1'b1)
                  is_img: begin
                     state_n    = S_WAIT_IMG;
                     count_n    = '0;
                     skid_vld_n = 1'b0;
                  end
                  is_clr: state_n = S_CLEAR;
                  is_rd:  load = 1'b1;
                  default: begin
                     bad   = 1'b1;
                     err_n = ERR_BAD_CMD;
                  end
               endcase
            end
         end
         S_WAIT_IMG, S_IMG_RX: begin
            if (new_byte && skid_vld) begin
               taken      = 1'b1;
               state_n    = S_ERROR;
               err_n      = ERR_OVERRUN;
               skid_vld_n = 1'b0;
            end else if (expired) begin
               state_n    = S_ERROR;
               err_n      = ERR_TIMEOUT;
               skid_vld_n = 1'b0;
            end else if (skid_vld && bus.wr_ready) begin
               issue      = 1'b1;
               issue_dat  = skid_dat;
               skid_vld_n = 1'b0;
               state_n    = S_WR_WAIT;
            end else if (new_byte && bus.wr_ready) begin
               issue     = 1'b1;
               issue_dat = bus.rx_data;
               state_n   = S_WR_WAIT;
            end else if (new_byte) begin
               skid_vld_n = 1'b1;
               skid_dat_n = bus.rx_data;
            end
         end
         S_WR_WAIT: begin
            if (bus.wr_ack) begin
               taken   = 1'b1;
               count_n = count + ADDR_W'(1);
               if (count == LAST) begin
                  state_n = S_BNN_RUN;
                  start   = 1'b1;
               end else begin
                  state_n = S_IMG_RX;
               end
            end else if (expired) begin
               state_n    = S_ERROR;
               err_n      = ERR_TIMEOUT;
               skid_vld_n = 1'b0;
            end
            // ack is handled first; a byte racing it parks in the skid
            if (new_byte && !(bus.wr_ack && count == LAST)) begin
               if (skid_vld) begin
                  taken      = 1'b1;
                  state_n    = S_ERROR;
                  err_n      = ERR_OVERRUN;
                  skid_vld_n = 1'b0;
               end else begin
                  skid_vld_n = 1'b1;
                  skid_dat_n = bus.rx_data;
               end
            end
         end
         S_BNN_RUN: begin
            if (new_byte) taken = 1'b1;
            if (new_byte && is_clr) begin
               state_n = S_CLEAR;
            end else if (bus.bnn_done) begin
               res_n   = bus.bnn_result;
               state_n = S_RESULT;
            end
         end
         S_RESULT: begin
            if (new_byte) begin
               taken = 1'b1;
               if (is_rd) load = 1'b1;
               else if (is_clr) state_n = S_CLEAR;
            end
         end
         S_ERROR: begin
            if (new_byte) begin
               taken = 1'b1;
               if (is_clr) state_n = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (new_byte) taken = 1'b1;
            count_n    = '0;
            err_n      = ERR_NONE;
            skid_vld_n = 1'b0;
            if (bus.buffer_empty) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         rx_q            <= 1'b0;
         count           <= '0;
         skid_vld        <= 1'b0;
         skid_dat        <= '0;
         res_q           <= '0;
         err_q           <= ERR_NONE;
         bus.rx_taken    <= 1'b0;
         bus.rx_enable   <= 1'b0;
         bus.wr_req      <= 1'b0;
         bus.wr_data     <= '0;
         bus.clear       <= 1'b0;
         bus.bnn_start   <= 1'b0;
         bus.tx_load     <= 1'b0;
         bus.tx_data     <= '0;
         bus.status_code <= ST_IDLE;
      end else begin
         state           <= state_n;
         rx_q            <= bus.rx_valid;
         count           <= count_n;
         skid_vld        <= skid_vld_n;
         skid_dat        <= skid_dat_n;
         res_q           <= res_n;
         err_q           <= err_n;
         bus.rx_taken    <= taken;
         bus.rx_enable   <= state_n != S_CLEAR;
         bus.wr_req      <= issue;
         bus.clear       <= state_n == S_CLEAR;
         bus.bnn_start   <= start;
         bus.tx_load     <= load;
         bus.status_code <= bad ? ST_ERROR : status_of(state);
         if (issue) bus.wr_data <= issue_dat;
         if (load) bus.tx_data <= DATA_W'(res_q);
      end
   end

   assign bus.wr_addr  = count;
   assign bus.err_code = err_q;
endmodule

// File: tb/tb_bnn_host_ctrl_fsm.sv
// Directed + randomized bench for bnn_host_ctrl_fsm (IMG_BYTES=4).
module tb_bnn_host_ctrl_fsm;
   localparam int DW = 8;
   localparam int IB = 4;
   localparam int AW = 2;
   localparam int RW = 4;
   localparam int TO = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bnn_host_ctrl_fsm_if #(
      .DATA_W(DW), .ADDR_W(AW), .RESULT_W(RW)
   ) bif ();

   bnn_host_ctrl_fsm #(
      .DATA_W(DW), .IMG_BYTES(IB), .ADDR_W(AW),
      .RESULT_W(RW), .TIMEOUT_CYC(TO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bif)
   );

   int tests = 0;
   int fails = 0;

   logic [AW+DW-1:0] wq[$];
   logic [DW-1:0]    txq[$];
   logic [3:0]       stq[$];
   logic [3:0]       last_st = 4'd0;
   int               taken_cnt = 0;
   int               start_cnt = 0;
   bit               clr_seen = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bif.wr_req) wq.push_back({bif.wr_addr, bif.wr_data});
         if (bif.tx_load) txq.push_back(bif.tx_data);
         if (bif.rx_taken) taken_cnt++;
         if (bif.bnn_start) start_cnt++;
         if (bif.clear) clr_seen = 1'b1;
         if (bif.status_code !== last_st) begin
            stq.push_back(bif.status_code);
            last_st = bif.status_code;
         end
      end
   end

   // buffer model: ack after ack_dly cycles, empty after 6 clear cycles
   int ack_dly = 1;
   int ack_tmr = 0;
   int clr_tmr = 0;
   always @(posedge clk) begin
      #2;
      bif.wr_ack = 1'b0;
      if (!rst_n) begin
         ack_tmr = 0;
         clr_tmr = 0;
         bif.buffer_empty = 1'b0;
      end else begin
         if (ack_tmr > 0) begin
            ack_tmr--;
            if (ack_tmr == 0) bif.wr_ack = 1'b1;
         end
         if (bif.wr_req) ack_tmr = ack_dly;
         if (bif.clear) begin
            clr_tmr++;
            bif.buffer_empty = clr_tmr >= 6;
         end else begin
            clr_tmr = 0;
            bif.buffer_empty = 1'b0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      bif.rx_data  = b;
      bif.rx_valid = 1'b1;
      tick(2);
      bif.rx_valid = 1'b0;
      tick(1);
   endtask

   task automatic do_clear();
      int n;
      send(8'hFD);
      n = 0;
      while (!bif.clear && n < 20) begin
         tick();
         n++;
      end
      check("clear_high", bif.clear, 1);
      check("clear_rx_enable", bif.rx_enable, 0);
      n = 0;
      while (bif.clear && n < 50) begin
         tick();
         n++;
      end
      check("clear_released", bif.clear, 0);
      tick(2);
      check("clear_status", bif.status_code, 0);
      check("clear_err", bif.err_code, 0);
   endtask

   // reference: writes are payload[i] at addr i, status walks 1,2,4,8
   task automatic run_frame(input string nm, input logic [7:0] p [IB],
                            input logic [3:0] r, input int dly);
      int s0, t0, n;
      logic [3:0] exp_st [4];
      exp_st = '{4'd1, 4'd2, 4'd4, 4'd8};
      wq.delete();
      txq.delete();
      stq.delete();
      last_st  = bif.status_code;
      clr_seen = 1'b0;
      s0 = start_cnt;
      t0 = taken_cnt;
      ack_dly = dly;
      send(8'hFE);
      for (int i = 0; i < IB; i++) begin
         send(p[i]);
         tick($urandom_range(3, 8));
      end
      n = 0;
      while (start_cnt == s0 && n < 200) begin
         tick();
         n++;
      end
      tick(2);
      check({nm, "_start_once"}, start_cnt - s0, 1);
      check({nm, "_no_clear"}, clr_seen, 0);
      check({nm, "_wr_count"}, wq.size(), IB);
      for (int i = 0; i < IB; i++) begin
         logic [AW-1:0] a;
         a = AW'(i);
         if (i < wq.size())
            check({nm, "_wr"}, wq[i], {a, p[i]});
      end
      tick($urandom_range(1, 4));
      bif.bnn_result = r;
      bif.bnn_done   = 1'b1;
      tick();
      bif.bnn_done   = 1'b0;
      tick(3);
      check({nm, "_status_result"}, bif.status_code, 8);
      send(8'hFC);
      tick(3);
      check({nm, "_tx_count"}, txq.size(), 1);
      if (txq.size() > 0)
         check({nm, "_tx_data"}, txq[0], {4'd0, r});
      check({nm, "_status_len"}, stq.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < stq.size())
            check({nm, "_status_seq"}, stq[i], exp_st[i]);
      do_clear();
      check({nm, "_taken"}, taken_cnt - t0, IB + 3);
   endtask

   initial begin
      logic [7:0] pl [IB];
      int n;
      int t0;
      bif.rx_valid   = 1'b0;
      bif.rx_data    = '0;
      bif.wr_ready   = 1'b1;
      bif.bnn_done   = 1'b0;
      bif.bnn_result = '0;
      rst_n = 1'b0;
      tick(3);
      check("rst_status", bif.status_code, 0);
      check("rst_err", bif.err_code, 0);
      check("rst_rx_enable", bif.rx_enable, 0);
      check("rst_wr_req", bif.wr_req, 0);
      check("rst_clear", bif.clear, 0);
      check("rst_tx_load", bif.tx_load, 0);
      check("rst_tx_data", bif.tx_data, 0);
      check("rst_wr_addr", bif.wr_addr, 0);
      rst_n = 1'b1;
      tick(2);
      check("idle_rx_enable", bif.rx_enable, 1);

      t0 = taken_cnt;
      stq.delete();
      last_st = bif.status_code;
      send(8'h55);
      tick(3);
      check("bad_taken", taken_cnt - t0, 1);
      check("bad_err", bif.err_code, 1);
      check("bad_status_len", stq.size(), 2);
      if (stq.size() == 2) begin
         check("bad_status_err", stq[0], 14);
         check("bad_status_back", stq[1], 0);
      end
      txq.delete();
      send(8'hFC);
      tick(3);
      check("read_rst_count", txq.size(), 1);
      if (txq.size() > 0) check("read_rst_data", txq[0], 0);

      pl = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_frame("nominal", pl, 4'd7, 1);
      pl = '{8'hFD, 8'hFE, 8'h01, 8'h02};
      run_frame("cmd_payload", pl, 4'($urandom_range(0, 15)),
                $urandom_range(1, 3));
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < IB; i++) pl[i] = 8'($urandom);
         run_frame("random", pl, 4'($urandom_range(0, 15)),
                   $urandom_range(1, 3));
      end

      wq.delete();
      ack_dly = 1;
      send(8'hFE);
      send(8'hA1);
      tick(4);
      bif.wr_ready = 1'b0;
      send(8'hA2);
      tick(17);
      check("bp_hold", wq.size(), 1);
      bif.wr_ready = 1'b1;
      tick(5);
      check("bp_release", wq.size(), 2);
      if (wq.size() == 2) check("bp_write", wq[1], {2'd1, 8'hA2});
      bif.wr_ready = 1'b0;
      send(8'hA3);
      send(8'hA4);
      tick(3);
      check("overrun_err", bif.err_code, 3);
      check("overrun_status", bif.status_code, 14);
      bif.wr_ready = 1'b1;
      do_clear();

      send(8'hFE);
      tick(900);
      check("timeout_early", bif.status_code, 1);
      n = 0;
      while (bif.status_code != 4'd14 && n < 200) begin
         tick();
         n++;
      end
      check("timeout_status", bif.status_code, 14);
      check("timeout_err", bif.err_code, 2);
      do_clear();

      send(8'hFE);
      send(8'hB1);
      tick(4);
      bif.rx_data  = 8'hB2;
      bif.rx_valid = 1'b1;
      tick(1);
      check("pre_rst_wr_req", bif.wr_req, 1);
      rst_n = 1'b0;
      #1;
      bif.rx_valid = 1'b0;
      check("midrst_wr_req", bif.wr_req, 0);
      check("midrst_status", bif.status_code, 0);
      check("midrst_rx_enable", bif.rx_enable, 0);
      check("midrst_wr_addr", bif.wr_addr, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      for (int i = 0; i < IB; i++) pl[i] = 8'($urandom);
      run_frame("after_rst", pl, 4'($urandom_range(0, 15)), 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
